// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-requester round-robin arbiter in front of a 1R1W RAM.
// Define RAM_ARB_RD_WR_FWD_EN to forward same-cycle write data to the read.
module ram_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 256,
    parameter int HOLD_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            rd_req,
    input  logic [2*ADDR_W-1:0]   rd_addr,
    output logic [1:0]            rd_gnt,
    output logic [1:0]            rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    input  logic [1:0]            wr_req,
    input  logic [2*ADDR_W-1:0]   wr_addr,
    input  logic [2*DATA_W-1:0]   wr_data,
    output logic [1:0]            wr_gnt,
    output logic [ADDR_W-1:0]     mem_rd_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_W-1:0]     mem_rd_data,
    output logic [ADDR_W-1:0]     mem_wr_addr,
    output logic [DATA_W-1:0]     mem_wr_data,
    output logic                  mem_wr_en,
    output logic [1:0]            addr_err
);

    localparam logic [7:0]      HMAX    = 8'(HOLD_MAX);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic              rd_o_q, rd_o_d, wr_o_q, wr_o_d;
    logic [7:0]        rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [1:0]        rd_valid_q, addr_err_q;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_hit, rd_oor, wr_hit, wr_oor;

    function automatic logic [1:0] arb(input logic [1:0] req,
                                       input logic o,
                                       input logic [7:0] cnt);
        logic [1:0] g;
        g = '0;
        if (req[o] && cnt < HMAX)
            g[o] = 1'b1;
        else if (req[~o])
            g[~o] = 1'b1;
        else if (req[o])
            g[o] = 1'b1;
        return g;
    endfunction

    // Returns {owner, count} after one cycle with grant g.
    function automatic logic [8:0] upd(input logic [1:0] g,
                                       input logic o,
                                       input logic [7:0] cnt);
        logic [8:0] r;
        if (g == 2'b00)
            r = {o, 8'd0};
        else if (g[o])
            r = {o, (cnt >= HMAX) ? HMAX : cnt + 8'd1};
        else
            r = {~o, 8'd1};
        return r;
    endfunction

    always_comb begin
        rd_gnt = '0;
        wr_gnt = '0;
        if (rst_n) begin
            rd_gnt = arb(rd_req, rd_o_q, rd_cnt_q);
            wr_gnt = arb(wr_req, wr_o_q, wr_cnt_q);
        end
    end

    assign {rd_o_d, rd_cnt_d} = upd(rd_gnt, rd_o_q, rd_cnt_q);
    assign {wr_o_d, wr_cnt_d} = upd(wr_gnt, wr_o_q, wr_cnt_q);

    always_comb begin
        mem_rd_addr = '0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        unique case (1'b1)
            rd_gnt[0]: mem_rd_addr = rd_addr[ADDR_W-1:0];
            rd_gnt[1]: mem_rd_addr = rd_addr[2*ADDR_W-1:ADDR_W];
            default: ;
        endcase
        unique case (1'b1)
            wr_gnt[0]: begin
                mem_wr_addr = wr_addr[ADDR_W-1:0];
                mem_wr_data = wr_data[DATA_W-1:0];
            end
            wr_gnt[1]: begin
                mem_wr_addr = wr_addr[2*ADDR_W-1:ADDR_W];
                mem_wr_data = wr_data[2*DATA_W-1:DATA_W];
            end
            default: ;
        endcase
    end

    assign rd_hit    = |rd_gnt;
    assign wr_hit    = |wr_gnt;
    assign rd_oor    = {1'b0, mem_rd_addr} >= DEPTH_L;
    assign wr_oor    = {1'b0, mem_wr_addr} >= DEPTH_L;
    assign mem_rd_en = rd_hit;
    assign mem_wr_en = wr_hit && !wr_oor;

`ifdef RAM_ARB_RD_WR_FWD_EN
    logic fwd;
    assign fwd = mem_wr_en && rd_hit && !rd_oor &&
                 (mem_rd_addr == mem_wr_addr);
`endif

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_hit) begin
            if (rd_oor)
                rd_data_d = '0;
`ifdef RAM_ARB_RD_WR_FWD_EN
            else if (fwd)
                rd_data_d = mem_wr_data;
`endif
            else
                rd_data_d = mem_rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_o_q     <= 1'b1;
            wr_o_q     <= 1'b1;
            rd_cnt_q   <= HMAX;
            wr_cnt_q   <= HMAX;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            addr_err_q <= '0;
        end else begin
            rd_o_q     <= rd_o_d;
            wr_o_q     <= wr_o_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_valid_q <= rd_gnt;
            rd_data_q  <= rd_data_d;
            addr_err_q <= {wr_hit && wr_oor, rd_hit && rd_oor};
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random checks of ram_port_arbiter
// against a behavioural reference model and two RAM stubs.
module tb_ram_port_arbiter;

    localparam int H = 4;

    logic        clk, rst_n;
    logic [1:0]  rd_req, rd_gnt, rd_valid, wr_req, wr_gnt, addr_err;
    logic [31:0] rd_addr, wr_addr, wr_data;
    logic [15:0] rd_data, mem_rd_addr, mem_rd_data;
    logic [15:0] mem_wr_addr, mem_wr_data;
    logic        mem_rd_en, mem_wr_en;
    logic [15:0] ram0 [256] = '{default: 16'h0};

    logic [1:0]  w1_req, w1_gnt, r1_gnt, r1_valid, e1;
    logic [31:0] w1_addr, w1_data;
    logic [15:0] r1_data, mr1_addr, mr1_data, mw1_addr, mw1_data;
    logic        mr1_en, mw1_en;
    logic [15:0] ram1 [256] = '{default: 16'h0};

    ram_port_arbiter #(.HOLD_MAX(H)) u0 (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_gnt(wr_gnt),
        .mem_rd_addr(mem_rd_addr), .mem_rd_en(mem_rd_en),
        .mem_rd_data(mem_rd_data),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_en(mem_wr_en), .addr_err(addr_err)
    );

    ram_port_arbiter #(.HOLD_MAX(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .rd_req(2'b00), .rd_addr(32'h0), .rd_gnt(r1_gnt),
        .rd_valid(r1_valid), .rd_data(r1_data),
        .wr_req(w1_req), .wr_addr(w1_addr), .wr_data(w1_data),
        .wr_gnt(w1_gnt),
        .mem_rd_addr(mr1_addr), .mem_rd_en(mr1_en),
        .mem_rd_data(mr1_data),
        .mem_wr_addr(mw1_addr), .mem_wr_data(mw1_data),
        .mem_wr_en(mw1_en), .addr_err(e1)
    );

    assign mem_rd_data = ram0[mem_rd_addr[7:0]];
    assign mr1_data    = ram1[mr1_addr[7:0]];

    always @(posedge clk) begin
        if (mem_wr_en) ram0[mem_wr_addr[7:0]] <= mem_wr_data;
        if (mw1_en)    ram1[mw1_addr[7:0]]    <= mw1_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          m_last[2];
    int          m_streak[2];
    logic [15:0] refmem [256] = '{default: 16'h0};
    logic [15:0] exp_rdata;
    logic [1:0]  obs_rg, obs_wg;
    logic        obs_wen;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Contention goes to the last winner until it has had H grants in a
    // row; a lone requester always wins.
    function automatic logic [1:0] mgnt(input int p, input logic [1:0] req);
        int w;
        if (req != 2'b11) return req;
        w = (m_streak[p] < H) ? m_last[p] : 1 - m_last[p];
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic void mupd(input int p, input logic [1:0] g);
        int w;
        if (g == 2'b00) begin
            m_streak[p] = 0;
        end else begin
            w = g[1] ? 1 : 0;
            if (w == m_last[p]) begin
                m_streak[p] = (m_streak[p] + 1 > H) ? H : m_streak[p] + 1;
            end else begin
                m_last[p]   = w;
                m_streak[p] = 1;
            end
        end
    endfunction

    task automatic step();
        logic [1:0]  eg_r, eg_w, ee;
        logic [15:0] ra, wa, wd;
        logic        ewen;
        @(negedge clk);
        eg_r = mgnt(0, rd_req);
        eg_w = mgnt(1, wr_req);
        ra   = eg_r[1] ? rd_addr[31:16] : rd_addr[15:0];
        wa   = eg_w[1] ? wr_addr[31:16] : wr_addr[15:0];
        wd   = eg_w[1] ? wr_data[31:16] : wr_data[15:0];
        ewen = (eg_w != 2'b00) && (wa < 16'd256);
        obs_rg  = rd_gnt;
        obs_wg  = wr_gnt;
        obs_wen = mem_wr_en;
        chk("rd_gnt", rd_gnt, eg_r);
        chk("wr_gnt", wr_gnt, eg_w);
        chk("mem_rd_en", mem_rd_en, eg_r != 2'b00);
        chk("mem_wr_en", mem_wr_en, ewen);
        chk("mem_rd_addr", mem_rd_addr, (eg_r != 2'b00) ? ra : 16'h0);
        if (eg_r != 2'b00) begin
            if (ra >= 16'd256) begin
                exp_rdata = 16'h0;
            end else begin
                exp_rdata = refmem[ra[7:0]];
`ifdef RAM_ARB_RD_WR_FWD_EN
                if (ewen && wa == ra) exp_rdata = wd;
`endif
            end
        end
        ee = {(eg_w != 2'b00) && (wa >= 16'd256),
              (eg_r != 2'b00) && (ra >= 16'd256)};
        @(posedge clk);
        #1;
        if (ewen) refmem[wa[7:0]] = wd;
        mupd(0, eg_r);
        mupd(1, eg_w);
        chk("rd_valid", rd_valid, eg_r);
        chk("rd_data", rd_data, exp_rdata);
        chk("addr_err", addr_err, ee);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        rd_req = '0;
        wr_req = '0;
        w1_req = '0;
        @(negedge clk);
        chk("rst_rd_gnt", rd_gnt, 2'b00);
        @(posedge clk);
        #1;
        chk("rst_rd_valid", rd_valid, 2'b00);
        chk("rst_rd_data", rd_data, 16'h0);
        chk("rst_addr_err", addr_err, 2'b00);
        rst_n       = 1'b1;
        m_last      = '{1, 1};
        m_streak    = '{H, H};
        exp_rdata   = 16'h0;
    endtask

    logic [1:0] pat [12] = '{2'b01, 2'b01, 2'b01, 2'b01,
                             2'b10, 2'b10, 2'b10, 2'b10,
                             2'b01, 2'b01, 2'b01, 2'b01};

    initial begin
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        w1_addr = '0;
        w1_data = '0;
        do_reset();

        // write then read back through the other requester
        wr_req  = 2'b01;
        wr_addr = {16'h0, 16'h0010};
        wr_data = {16'h0, 16'hBEEF};
        step();
        chk("t1_wgnt", obs_wg, 2'b01);
        wr_req  = 2'b00;
        rd_req  = 2'b10;
        rd_addr = {16'h0010, 16'h0};
        step();
        chk("t1_rgnt", obs_rg, 2'b10);
        chk("t1_valid", rd_valid, 2'b10);
        chk("t1_data", rd_data, 16'hBEEF);

        // round-robin under contention with hold limit 4
        do_reset();
        rd_req  = 2'b11;
        rd_addr = {16'h0005, 16'h0003};
        for (int i = 0; i < 12; i++) begin
            step();
            chk("t2_pattern", obs_rg, pat[i]);
        end

        // strict alternation with hold limit 1
        do_reset();
        w1_req  = 2'b11;
        w1_addr = {16'h0040, 16'h0040};
        for (int k = 0; k < 6; k++) begin
            w1_data = {16'hB000 + 16'(k), 16'hA000 + 16'(k)};
            @(negedge clk);
            chk("t3_wgnt", w1_gnt, (k % 2 == 1) ? 2'b10 : 2'b01);
            @(posedge clk);
            #1;
        end
        w1_req = 2'b00;
        chk("t3_ram", ram1[8'h40], 16'hB005);

        // same-cycle read and write to one address
        do_reset();
        rd_req  = 2'b00;
        wr_req  = 2'b01;
        wr_addr = {16'h0, 16'h0020};
        wr_data = {16'h0, 16'h1111};
        step();
        rd_req  = 2'b01;
        rd_addr = {16'h0, 16'h0020};
        wr_req  = 2'b10;
        wr_addr = {16'h0020, 16'h0};
        wr_data = {16'h2222, 16'h0};
        step();
`ifdef RAM_ARB_RD_WR_FWD_EN
        chk("t4_same", rd_data, 16'h2222);
`else
        chk("t4_same", rd_data, 16'h1111);
`endif
        wr_req = 2'b00;
        step();
        chk("t4_after", rd_data, 16'h2222);

        // out-of-range write then read; word 0 is non-zero so aliasing shows
        rd_req  = 2'b00;
        wr_req  = 2'b01;
        wr_addr = {16'h0, 16'h0000};
        wr_data = {16'h0, 16'h5A5A};
        step();
        wr_addr = {16'h0, 16'h0100};
        wr_data = {16'h0, 16'hDEAD};
        step();
        chk("t5_wgnt", obs_wg, 2'b01);
        chk("t5_wen", obs_wen, 1'b0);
        chk("t5_werr", addr_err, 2'b10);
        wr_req  = 2'b00;
        rd_req  = 2'b01;
        rd_addr = {16'h0, 16'h0100};
        step();
        chk("t5_rvalid", rd_valid, 2'b01);
        chk("t5_rdata", rd_data, 16'h0);
        chk("t5_rerr", addr_err, 2'b01);

        // reset in the middle of a cycle
        rd_addr = {16'h0, 16'h0010};
        step();
        chk("t6_valid", rd_valid, 2'b01);
        wr_req  = 2'b01;
        wr_addr = {16'h0, 16'h0011};
        wr_data = {16'h0, 16'h7777};
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_clr", rd_valid, 2'b00);
        chk("t6_rgnt", rd_gnt, 2'b00);
        chk("t6_wgnt", wr_gnt, 2'b00);
        chk("t6_wen", mem_wr_en, 1'b0);
        @(posedge clk);
        #1;
        chk("t6_nowrite", ram0[8'h11], 16'h0);
        rst_n     = 1'b1;
        m_last    = '{1, 1};
        m_streak  = '{H, H};
        exp_rdata = 16'h0;
        wr_req    = 2'b00;
        rd_req    = 2'b11;
        rd_addr   = {16'h0007, 16'h0006};
        step();
        chk("t6_first", obs_rg, 2'b01);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            rd_req = 2'($urandom);
            wr_req = 2'($urandom);
            for (int j = 0; j < 2; j++) begin
                rd_addr[j*16 +: 16] = ($urandom_range(0, 9) == 0) ?
                    16'h0100 + 16'($urandom_range(0, 255)) :
                    16'($urandom_range(0, 15));
                wr_addr[j*16 +: 16] = ($urandom_range(0, 9) == 0) ?
                    16'h0100 + 16'($urandom_range(0, 255)) :
                    16'($urandom_range(0, 15));
                wr_data[j*16 +: 16] = 16'($urandom);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the 256x16 dual-port RAM (one combinational read port, one posedge write port) between two requesters, e.g. core and DMA.
- Read port and write port are arbitrated independently, so a read from one requester and a write from the other can complete in the same cycle.
- Each port uses last-owner-priority round-robin with a bounded hold counter.
- Read data is registered toward the requesters. Out-of-range addresses are trapped.

Parameters:
- ADDR_W, 16, address width of requester and RAM ports
- DATA_W, 16, data width
- DEPTH, 256, number of valid RAM words; address >= DEPTH is out of range
- HOLD_MAX, 4, max consecutive grants to one requester while the other waits; legal range 1..255

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_req  in  2  read request, bit i = requester i
- rd_addr  in  2*ADDR_W  read addresses, requester i at [i*ADDR_W +: ADDR_W]
- rd_gnt  out  2  read grant, combinational, one-hot or zero
- rd_valid  out  2  registered; bit i high the cycle after requester i was read-granted
- rd_data  out  DATA_W  registered read data, qualified by rd_valid
- wr_req  in  2  write request
- wr_addr  in  2*ADDR_W  write addresses
- wr_data  in  2*DATA_W  write data
- wr_gnt  out  2  write grant, combinational, one-hot or zero; the write commits at the closing edge of the grant cycle
- mem_rd_addr  out  ADDR_W  to RAM read address
- mem_rd_en  out  1  to RAM read enable
- mem_rd_data  in  DATA_W  from RAM read value
- mem_wr_addr  out  ADDR_W  to RAM write address
- mem_wr_data  out  DATA_W  to RAM write value
- mem_wr_en  out  1  to RAM write enable
- addr_err  out  2  registered; bit0 = read address error, bit1 = write address error; one-cycle pulse

Behaviour:
- Each port (read, write) has its own owner register `o` (1 bit) and hold counter `cnt` (8 bits).
- Reset values: o=1, cnt=HOLD_MAX, rd_valid=0, rd_data=0, addr_err=0.
- While rst_n is low, all grants and mem_*_en are forced to 0.
- Grant rule for each port, evaluated combinationally in priority order:
  - (1) req[o] && cnt<HOLD_MAX -> grant o;
  - (2) else req[~o] -> grant ~o;
  - (3) else req[o] -> grant o;
  - (4) else no grant.
- Owner/counter update at each edge:
  - grant to o: cnt <= min(cnt+1, HOLD_MAX);
  - grant to ~o: o <= ~o, cnt <= 1;
  - no grant: cnt <= 0, o unchanged (the idle owner regains first claim).
- HOLD_MAX=1 gives strict alternation under contention. A lone requester is granted every cycle indefinitely.
- RAM-side muxing:
  - mem_rd_addr = granted requester's address, else 0; mem_rd_en = |rd_gnt.
  - mem_wr_addr and mem_wr_data follow the same rule; mem_wr_en = |wr_gnt && address in range.
- Read latency is 1 cycle: rd_data <= mem_rd_data and rd_valid <= rd_gnt at the edge closing the grant cycle. rd_valid is 0 in every cycle without a prior grant; rd_data holds its last value.
- Out-of-range read (granted addr >= DEPTH):
  - the grant is still given and rd_valid still pulses;
  - rd_data <= 0, addr_err[0] pulses the next cycle.
- Out-of-range write (granted addr >= DEPTH):
  - the grant is still given (the requester is released);
  - mem_wr_en=0, so the write is dropped;
  - addr_err[1] pulses the next cycle.
- A same-cycle read and write to the same in-range address, with no forwarding, returns the OLD contents.
- A request dropped while it is owner frees the port that cycle, with no bubble.
- Reset asserted mid-operation: a pending rd_valid is cleared immediately, and no partial write occurs because mem_wr_en is gated by rst_n.

Optional Feature:
- Macro: RAM_ARB_RD_WR_FWD_EN.
- Defined: when a read grant and a write grant target the same in-range address in the same cycle, rd_data captures the granted wr_data instead of mem_rd_data, giving write-before-read semantics.
- Undefined: rd_data always captures mem_rd_data, giving old-data semantics.

Test Plan:
- Reset, then write 0xBEEF @0x10 by req0; next cycle read @0x10 by req1 -> wr_gnt=01 in cycle 0; rd_gnt=10; rd_valid=10 and rd_data=0xBEEF one cycle after the read grant.
- Both requesters hold rd_req=11 for 12 cycles, HOLD_MAX=4 -> first grant to req0 (reset o=1, cnt saturated); grant pattern 0,0,0,0,1,1,1,1,0,0,0,0.
- HOLD_MAX=1, wr_req=11 for 6 cycles -> wr_gnt alternates 01,10,01,10,01,10; RAM contents match the last writer per address.
- Same cycle: read req0 @0x20 (holding 0x1111), write req1 @0x20 value 0x2222 -> rd_data=0x1111 without the macro, 0x2222 with RAM_ARB_RD_WR_FWD_EN; the following read returns 0x2222.
- Write @0x0100 (DEPTH=256) -> wr_gnt given, mem_wr_en=0, addr_err=10 next cycle; read @0x0100 -> rd_data=0, addr_err=01.
- Read granted, then rst_n dropped before the next edge -> rd_valid=00 immediately; after release, o=1 and cnt=HOLD_MAX, and contention grants req0 first.
